// File: rtl/bidir_pkg.sv
// Shared constants for the bidirectional pad cell.
// Direction encodings and the default bus width.
package bidir_pkg;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int WIDTH_DEF = 4;
  localparam int SYNC_MAX  = 3;

endpackage

// File: rtl/bidir_sync_chain.sv
// Input sampling shift chain for the pad cell.
// Ports: clk, rst (async, active-high), d (raw pin),
//   q (last stage), q_d (value q takes at next edge).
module bidir_sync_chain
  import bidir_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_d
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q   = stage_q[SYNC_STAGES-1];
  // Exposed so the change detector can flag a change
  // in the same cycle data_in takes the new value.
  assign q_d = stage_d[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_pin_cell.sv
// Bidirectional pad cell: tri-state drive plus sampled input.
// Ports: clk, rst, dir, data_out -> pin; pin -> data_in, in_changed.
module bidir_pin_cell
  import bidir_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  inout  wire  [WIDTH-1:0] pin,
  output logic             in_changed
);

  logic             oe;
  logic [WIDTH-1:0] tail_d;
  logic             in_changed_q;
  logic             in_changed_d;

  // Drive path is purely combinational; reset
  // releases the pad immediately.
  assign oe  = (dir == DIR_OUT) && !rst;
  assign pin = oe ? data_out : {WIDTH{1'bz}};

  bidir_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin),
    .q   (data_in),
    .q_d (tail_d)
  );

  always_comb begin
    in_changed_d = (tail_d != data_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_changed_q <= 1'b0;
    end else begin
      in_changed_q <= in_changed_d;
    end
  end

  assign in_changed = in_changed_q;

endmodule

// File: tb/tb_bidir_pin_cell.sv
// Self-checking bench for bidir_pin_cell.
// Random traffic against a sample-history model, plus directed cases.
module tb_bidir_pin_cell;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir = 1'b1;
  logic [3:0] data_out = 4'hF;
  logic [3:0] data_in;
  logic       in_changed;
  logic       ext_en = 1'b1;
  logic [3:0] ext_val = 4'h0;
  wire  [3:0] pin;

  logic       dir3 = 1'b0;
  logic [3:0] data_out3 = 4'h0;
  logic [3:0] data_in3;
  logic       in_changed3;
  logic [3:0] ext3 = 4'h0;
  wire  [3:0] pin3;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] q1[$];
  logic [3:0] q3[$];
  logic [3:0] old1;
  logic [3:0] old3;

  always #5 clk = ~clk;

  assign pin  = ext_en ? ext_val : 4'bzzzz;
  assign pin3 = ext3;

  bidir_pin_cell #(.WIDTH(4), .SYNC_STAGES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .dir        (dir),
    .data_out   (data_out),
    .data_in    (data_in),
    .pin        (pin),
    .in_changed (in_changed)
  );

  bidir_pin_cell #(.WIDTH(4), .SYNC_STAGES(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .dir        (dir3),
    .data_out   (data_out3),
    .data_in    (data_in3),
    .pin        (pin3),
    .in_changed (in_changed3)
  );

  always @(posedge clk) begin
    if (dir) begin
      assert (!$isunknown(data_out))
        else $error("data_out unknown while driving");
    end
  end

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    q1 = {};
    q3 = {};
    q1.push_back(4'h0);
    for (int i = 0; i < 3; i++) q3.push_back(4'h0);
    old1 = 4'h0;
    old3 = 4'h0;
  endfunction

  // Apply inputs mid-cycle; bench drives the bus only
  // when the cell is in input mode.
  task automatic drive(logic d, logic [3:0] dout,
                       logic [3:0] ext, logic [3:0] e3);
    @(negedge clk);
    dir      = d;
    data_out = dout;
    ext_val  = ext;
    ext_en   = !d;
    ext3     = e3;
    #1;
    chk("pin", pin, d ? dout : ext);
  endtask

  // One rising edge: the model records what the bus
  // carried, data_in is the sample SYNC_STAGES edges old.
  task automatic tick();
    logic [3:0] s1;
    logic [3:0] n1;
    logic [3:0] n3;
    @(posedge clk);
    s1 = dir ? data_out : ext_val;
    q1.push_back(s1);
    void'(q1.pop_front());
    q3.push_back(ext3);
    void'(q3.pop_front());
    #1;
    n1 = q1[0];
    n3 = q3[0];
    chk("data_in", data_in, n1);
    chk("in_changed", in_changed, n1 != old1);
    chk("data_in3", data_in3, n3);
    chk("in_changed3", in_changed3, n3 != old3);
    old1 = n1;
    old3 = n3;
  endtask

  // Async reset between edges with the cell told to
  // drive F; the bench holds 0 on the bus to expose
  // any drive leaking through reset.
  task automatic do_reset();
    @(posedge clk);
    #3;
    dir      = 1'b1;
    data_out = 4'hF;
    ext_en   = 1'b1;
    ext_val  = 4'h0;
    rst      = 1'b1;
    #1;
    chk("rst_pin", pin, 4'h0);
    chk("rst_data_in", data_in, 4'h0);
    chk("rst_in_changed", in_changed, 1'b0);
    chk("rst_data_in3", data_in3, 4'h0);
    chk("rst_in_changed3", in_changed3, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold", data_in, 4'h0);
    @(negedge clk);
    rst    = 1'b0;
    ext_en = 1'b0;
    #1;
    chk("rel_pin", pin, 4'hF);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_pin", pin, 4'h0);
    chk("init_data_in", data_in, 4'h0);
    chk("init_in_changed", in_changed, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    ext_en = 1'b0;
    #1;
    chk("rel_pin", pin, 4'hF);
    tick();

    // output loopback
    drive(1'b1, 4'hA, 4'h0, 4'h0);
    tick();
    chk("loop_A", data_in, 4'hA);
    tick();
    drive(1'b1, 4'h5, 4'h0, 4'h0);
    tick();
    chk("loop_5", data_in, 4'h5);
    chk("loop_chg", in_changed, 1'b1);
    tick();
    chk("loop_chg_end", in_changed, 1'b0);

    // input mode
    drive(1'b0, 4'hF, 4'h3, 4'h0);
    tick();
    chk("in_3", data_in, 4'h3);

    // turnaround 1->0
    drive(1'b1, 4'hC, 4'h0, 4'h0);
    tick();
    drive(1'b0, 4'h0, 4'h6, 4'h9);
    chk("turn_hold", data_in, 4'hC);
    tick();
    chk("turn_6", data_in, 4'h6);
    chk("turn_chg", in_changed, 1'b1);
    chk("sync3_e1", data_in3, 4'h0);
    tick();
    chk("turn_chg_end", in_changed, 1'b0);
    chk("sync3_e2", data_in3, 4'h0);
    tick();
    chk("sync3_e3", data_in3, 4'h9);
    chk("sync3_chg", in_changed3, 1'b1);

    // mid-operation reset
    drive(1'b1, 4'h7, 4'h0, 4'h2);
    tick();
    do_reset();
    tick();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)),
              4'($urandom), 4'($urandom),
              4'($urandom_range(0, 3) == 0 ?
                 $urandom : ext3));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
